// File: rtl/dma_ahb_pkg.sv
// Shared AHB encodings and read-master state type for the DMA channel.
package dma_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN,
    ST_ERR
  } rd_state_e;

endpackage

// File: rtl/dma_rd_skid.sv
// One-word skid register between the AHB data phase and the channel FIFO.
module dma_rd_skid
  import dma_ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] capture_data,
  input  logic                  full,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  skid_valid,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] skid_data
);

  assign push = skid_valid && !full && !hold;

  // A capture in the same cycle as a push replaces the outgoing word.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (capture) begin
      skid_valid <= 1'b1;
      skid_data  <= capture_data;
    end else if (push) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_ahb_rd_master.sv
// DMA channel AHB read master: fetches TransferCount words and pushes them to the FIFO.
module dma_ahb_rd_master
  import dma_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] SrcAddr,
  input  logic [CNT_WIDTH-1:0]  TransferCount,
  input  logic                  SrcIncr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  HBUSREQ,
  input  logic                  HGRANT,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  full,
  output logic                  WriteDataEnable,
  output logic [DATA_WIDTH-1:0] in_HRDATA_m
);

  rd_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  issue_cnt, data_cnt;
  logic                  incr_q, seq_ok, data_pending, skid_valid;
  logic                  err_now, err_end, capture, slot_ok, issue, accept;

  // RETRY and SPLIT are folded into ERROR: anything but OKAY aborts.
  assign err_now = data_pending && (HRESP != HRESP_OKAY);
  assign err_end = err_now && HREADY;
  assign capture = data_pending && HREADY && !err_now;
  assign slot_ok = (!skid_valid && !data_pending) || ((skid_valid ^ data_pending) && !full);
  assign issue   = (state == ST_XFER) && (issue_cnt != '0) && HGRANT && slot_ok && !err_now;
  assign accept  = issue && HREADY;

  assign HADDR  = addr_q;
  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = incr_q ? HBURST_INCR : HBURST_SINGLE;
  assign HTRANS = !issue ? HTRANS_IDLE :
                  (!incr_q || !seq_ok || (addr_q[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      issue_cnt    <= '0;
      data_cnt     <= '0;
      incr_q       <= 1'b0;
      seq_ok       <= 1'b0;
      data_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && Start) begin
        addr_q    <= SrcAddr & ~ADDR_WIDTH'(3);
        issue_cnt <= TransferCount;
        data_cnt  <= TransferCount;
        incr_q    <= SrcIncr;
        seq_ok    <= 1'b0;
      end else begin
        if (accept) begin
          issue_cnt <= issue_cnt - CNT_WIDTH'(1);
          if (incr_q) addr_q <= addr_q + ADDR_WIDTH'(4);
        end
        if (capture && data_cnt != '0) data_cnt <= data_cnt - CNT_WIDTH'(1);
        // Losing the grant breaks the burst; the next beat restarts as NONSEQ.
        if (!HGRANT)     seq_ok <= 1'b0;
        else if (accept) seq_ok <= 1'b1;
      end
      if (accept)      data_pending <= 1'b1;
      else if (HREADY) data_pending <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = (state != ST_IDLE);
    Done      = 1'b0;
    Error     = 1'b0;
    HBUSREQ   = (state == ST_REQ) || (state == ST_XFER);
    case (state)
      ST_IDLE:  if (Start) state_nxt = (TransferCount == '0) ? ST_DRAIN : ST_REQ;
      ST_REQ:   if (HGRANT && HREADY) state_nxt = ST_XFER;
      ST_XFER: begin
        if (err_end)                             state_nxt = ST_ERR;
        else if (accept && issue_cnt == CNT_WIDTH'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (err_end) begin
          state_nxt = ST_ERR;
        end else if (data_cnt == '0 && !skid_valid) begin
          Done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        Error     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  dma_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .capture      (capture),
    .capture_data (HRDATA),
    .full         (full),
    .hold         (err_end),
    .flush        (state == ST_ERR),
    .skid_valid   (skid_valid),
    .push         (WriteDataEnable),
    .skid_data    (in_HRDATA_m)
  );

endmodule

// File: tb/tb_dma_ahb_rd_master.sv
// Directed bench for dma_ahb_rd_master with an AHB slave and 16-deep FIFO model.
module tb_dma_ahb_rd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] SrcAddr = '0;
  logic [15:0] TransferCount = '0;
  logic        SrcIncr = 1'b0;
  logic        HGRANT = 1'b1;
  logic        rd_en = 1'b1;
  logic        Busy, Done, Error, HBUSREQ, HWRITE, HREADY, full, WriteDataEnable;
  logic [31:0] HADDR, HRDATA, in_HRDATA_m;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;

  dma_ahb_rd_master dut (
    .HCLK (HCLK), .HRESETn (HRESETn), .Start (Start), .SrcAddr (SrcAddr),
    .TransferCount (TransferCount), .SrcIncr (SrcIncr), .Busy (Busy), .Done (Done),
    .Error (Error), .HBUSREQ (HBUSREQ), .HGRANT (HGRANT), .HADDR (HADDR),
    .HTRANS (HTRANS), .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST),
    .HREADY (HREADY), .HRESP (HRESP), .HRDATA (HRDATA), .full (full),
    .WriteDataEnable (WriteDataEnable), .in_HRDATA_m (in_HRDATA_m)
  );

  always #5 HCLK = ~HCLK;

  // Slave: zero wait states; beat err_beat answers with a two-cycle ERROR.
  int          beat_no, ph_num;
  int          err_beat = -1;
  logic        ph_valid, err_ph;
  logic [31:0] ph_addr;
  logic        err_hit;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      ph_valid <= 1'b0;
      err_ph   <= 1'b0;
      beat_no  <= 0;
    end else begin
      if (Start) beat_no <= 0;
      if (HREADY) begin
        err_ph <= 1'b0;
        if (HTRANS[1] && HGRANT) begin
          ph_valid <= 1'b1;
          ph_addr  <= HADDR;
          ph_num   <= beat_no;
          beat_no  <= beat_no + 1;
        end else begin
          ph_valid <= 1'b0;
        end
      end else begin
        err_ph <= 1'b1;
      end
    end
  end

  assign err_hit = ph_valid && (ph_num == err_beat);
  assign HREADY  = !(err_hit && !err_ph);
  assign HRESP   = err_hit ? 2'b01 : 2'b00;
  assign HRDATA  = ph_valid ? (32'hD000_0000 | (32'(ph_num) << 16) | {16'h0, ph_addr[15:0]}) : 32'h0;

  int fifo_cnt;
  always @(posedge HCLK) begin
    if (!HRESETn) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + (WriteDataEnable ? 1 : 0) - ((rd_en && fifo_cnt > 0) ? 1 : 0);
  end
  assign full = (fifo_cnt >= 16);

  // Monitor, sampled mid low phase; logs restart on each Start.
  logic [31:0] push_log[$];
  logic [31:0] addr_log[$];
  logic [31:0] trans_log[$];
  int          cyc, done_cnt, err_cnt, last_push_cyc, done_cyc, gap_bad, err1_trans;
  logic [2:0]  burst_seen;

  always @(negedge HCLK) begin
    #1;
    cyc = cyc + 1;
    if (Start) begin
      push_log.delete(); addr_log.delete(); trans_log.delete();
      done_cnt = 0; err_cnt = 0; gap_bad = 0; err1_trans = -1;
    end
    if (WriteDataEnable) begin
      push_log.push_back(in_HRDATA_m);
      last_push_cyc = cyc;
    end
    if (HTRANS != 2'b00 && HREADY && HGRANT) begin
      addr_log.push_back(HADDR);
      trans_log.push_back(32'(HTRANS));
    end
    if (Done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (Error) err_cnt = err_cnt + 1;
    if (!HGRANT && HTRANS != 2'b00) gap_bad = gap_bad + 1;
    if (HRESP == 2'b01 && !HREADY) err1_trans = 32'(HTRANS);
    if (HTRANS != 2'b00) burst_seen = HBURST;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] c, input logic inc);
    @(negedge HCLK);
    SrcAddr = a; TransferCount = c; SrcIncr = inc; Start = 1'b1;
    @(negedge HCLK);
    Start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < max_cyc) begin
      @(negedge HCLK); #2;
      n++;
    end
    chk(tag, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int beats);
    int n = 0;
    while (addr_log.size() < beats && n < 60) begin
      @(posedge HCLK);
      n++;
    end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, 32'({HTRANS, HBUSREQ, Busy, Done, Error, WriteDataEnable}), 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk({tag, "_wdata"}, in_HRDATA_m, 32'd0);
  endtask

  logic [31:0] T1_DATA [4] = '{32'hD000_1000, 32'hD001_1004, 32'hD002_1008, 32'hD003_100C};
  logic [31:0] T35_TR  [4] = '{32'd2, 32'd3, 32'd2, 32'd3};

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge HCLK);
    #1 check_reset("reset");
    HRESETn = 1'b1;

    // Zero-wait incrementing burst of 4
    start_xfer(32'h1000, 16'd4, 1'b1);
    wait_end("t1_end", 50);
    chk("t1_naddr", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), at(addr_log, i), 32'h1000 + 32'(4 * i));
      chk($sformatf("t1_trans%0d", i), at(trans_log, i), (i == 0) ? 32'd2 : 32'd3);
      chk($sformatf("t1_data%0d", i), at(push_log, i), T1_DATA[i]);
    end
    chk("t1_npush", push_log.size(), 32'd4);
    chk("t1_done_lat", 32'(done_cyc - last_push_cyc), 32'd1);
    chk("t1_hburst", 32'(burst_seen), 32'd1);
    chk("t1_hsize_hwrite", 32'({HWRITE, HSIZE}), 32'd2);
    repeat (2) @(negedge HCLK);
    #2;
    chk("t1_busy_after", 32'(Busy), 32'd0);
    chk("t1_ndone", done_cnt, 32'd1);

    // 20 words into a stalled FIFO
    rd_en = 1'b0;
    start_xfer(32'h2000, 16'd20, 1'b1);
    repeat (80) @(negedge HCLK);
    #2;
    chk("t2_stall_npush", push_log.size(), 32'd16);
    chk("t2_stall_full", 32'(full), 32'd1);
    chk("t2_stall_htrans", 32'(HTRANS), 32'd0);
    chk("t2_stall_busy_done", 32'({Busy, Done}), 32'b10);
    rd_en = 1'b1;
    wait_end("t2_end", 200);
    chk("t2_npush", push_log.size(), 32'd20);
    for (int k = 0; k < 20; k++)
      chk($sformatf("t2_data%0d", k), at(push_log, k),
          32'hD000_0000 | (32'(k) << 16) | (32'h2000 + 32'(4 * k)));
    chk("t2_ndone", done_cnt, 32'd1);

    // 1KB boundary crossing, then fixed address
    start_xfer(32'h13F8, 16'd4, 1'b1);
    wait_end("t3a_end", 50);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3a_addr%0d", i), at(addr_log, i), 32'h13F8 + 32'(4 * i));
      chk($sformatf("t3a_trans%0d", i), at(trans_log, i), T35_TR[i]);
    end
    chk("t3a_data2", at(push_log, 2), 32'hD002_1400);
    start_xfer(32'h13F8, 16'd4, 1'b0);
    wait_end("t3b_end", 50);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3b_addr%0d", i), at(addr_log, i), 32'h13F8);
      chk($sformatf("t3b_trans%0d", i), at(trans_log, i), 32'd2);
    end
    chk("t3b_hburst", 32'(burst_seen), 32'd0);
    chk("t3b_data3", at(push_log, 3), 32'hD003_13F8);
    chk("t3b_npush", push_log.size(), 32'd4);

    // ERROR response on the third beat
    err_beat = 2;
    start_xfer(32'h3000, 16'd4, 1'b1);
    wait_end("t4_end", 50);
    repeat (3) @(negedge HCLK);
    #2;
    err_beat = -1;
    chk("t4_nerr", err_cnt, 32'd1);
    chk("t4_ndone", done_cnt, 32'd0);
    chk("t4_npush", push_log.size(), 32'd2);
    chk("t4_data0", at(push_log, 0), 32'hD000_3000);
    chk("t4_data1", at(push_log, 1), 32'hD001_3004);
    chk("t4_err1_htrans", err1_trans, 32'd0);
    chk("t4_busy_after", 32'(Busy), 32'd0);

    // Grant removed for 5 cycles after beat 2
    start_xfer(32'h4000, 16'd4, 1'b1);
    wait_beats("t5_beat2", 2);
    @(negedge HCLK);
    HGRANT = 1'b0;
    repeat (5) @(negedge HCLK);
    HGRANT = 1'b1;
    wait_end("t5_end", 50);
    chk("t5_gap_issue", gap_bad, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_trans%0d", i), at(trans_log, i), T35_TR[i]);
      chk($sformatf("t5_data%0d", i), at(push_log, i),
          32'hD000_0000 | (32'(i) << 16) | (32'h4000 + 32'(4 * i)));
    end

    // Asynchronous reset mid-transfer
    start_xfer(32'h5000, 16'd8, 1'b1);
    wait_beats("t6_beat3", 3);
    #2 HRESETn = 1'b0;
    #1 check_reset("t6_async");
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    #2;
    chk("t6_no_done_err", 32'(done_cnt + err_cnt), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);

    // Zero-length transfer
    start_xfer(32'h6000, 16'd0, 1'b1);
    #2;
    chk("t7_done_next", 32'(Done), 32'd1);
    chk("t7_no_bus", 32'({HBUSREQ, HTRANS}), 32'd0);
    repeat (3) @(negedge HCLK);
    #2;
    chk("t7_ndone", done_cnt, 32'd1);
    chk("t7_naddr", addr_log.size(), 32'd0);
    chk("t7_busy_after", 32'(Busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dma_ahb_rd_master.md
Name: dma_ahb_rd_master

Overview:
AHB read-master stage of the DMA channel. It fetches TransferCount 32-bit words from a source address over AHB and pushes each returned HRDATA word into the channel's 16-deep sync FIFO, which feeds the write side. A one-word skid register decouples the AHB data phase from FIFO back-pressure, so data never arrives with nowhere to go.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, AHB/FIFO data width (word transfers only)
CNT_WIDTH, 16, width of the transfer word count

Ports:
HCLK  in  1  system clock, all logic rising-edge
HRESETn  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse; latches config; ignored when Busy=1
SrcAddr  in  ADDR_WIDTH  start byte address; bits[1:0] ignored, treated as 0
TransferCount  in  CNT_WIDTH  number of words to read
SrcIncr  in  1  1: address += 4 per beat; 0: fixed address (peripheral)
Busy  out  1  high from the cycle after Start until the Done or Error pulse
Done  out  1  one-cycle pulse: all words pushed to FIFO
Error  out  1  one-cycle pulse: HRESP ERROR received, transfer aborted
HBUSREQ  out  1  bus request
HGRANT  in  1  bus grant
HADDR  out  ADDR_WIDTH  address
HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11
HWRITE  out  1  constant 0
HSIZE  out  3  constant 010 (word)
HBURST  out  3  INCR=001 when SrcIncr=1, SINGLE=000 when SrcIncr=0
HREADY  in  1  transfer done / wait
HRESP  in  2  OKAY=00, ERROR=01 (RETRY/SPLIT are not supported; treat them as ERROR)
HRDATA  in  DATA_WIDTH  read data
full  in  1  FIFO full
WriteDataEnable  out  1  FIFO push strobe
in_HRDATA_m  out  DATA_WIDTH  FIFO write data (skid register contents)

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HBUSREQ=0, Busy=0, Done=0, Error=0, WriteDataEnable=0, in_HRDATA_m=0, skid empty, state IDLE.
- An async reset mid-transfer drops everything immediately. The skid word is discarded and no Done or Error is produced.
- States:
  - IDLE. On Start with TransferCount=0, Done pulses the next cycle and there is no bus activity.
  - REQ: HBUSREQ=1; go to XFER when HGRANT=1 and HREADY=1.
  - XFER: issue address phases.
  - DRAIN: the last address has been issued; wait for the final data phase and the skid to empty.
  - ERR: one cycle; Error pulses and the block returns to IDLE.
- Counters:
  - issue_cnt counts remaining address phases.
  - data_cnt counts remaining data phases.
  - Both load TransferCount at Start; they are CNT_WIDTH bits and never underflow.
- Address issue: an address phase is accepted only on a cycle with HREADY=1 and HGRANT=1.
  - Issue is allowed only when slots = skid_valid + data_pending is 0, or is 1 with full=0.
  - With SrcIncr=1, the first beat and the first beat after any re-grant or 1KB-boundary crossing (HADDR[9:0]==0) are NONSEQ; all others are SEQ.
  - With SrcIncr=0, every beat is NONSEQ.
  - When issue is not allowed, drive HTRANS=IDLE. BUSY is never used.
- Data phase: on HREADY=1 with HRESP=OKAY, HRDATA is captured into the skid, skid_valid=1, and data_cnt decrements.
- Skid push: when skid_valid=1 and full=0, WriteDataEnable=1 for one cycle with in_HRDATA_m holding the skid word, then the skid clears. A capture and a push may occur in the same cycle; the skid then holds the new word.
- No overflow: a capture never occurs while skid_valid=1 and the skid is not pushing in that same cycle.
- Grant loss: HBUSREQ stays high while issue_cnt>0. An outstanding data phase still completes.
- Done: asserted when data_cnt=0 and skid empty. HBUSREQ drops when issue_cnt reaches 0.
- HRESP=ERROR:
  - First (HREADY=0) cycle: drive HTRANS=IDLE and cancel the pending address.
  - Second cycle: the word is not captured and the skid word is not pushed; go to ERR.
- Done and Error are mutually exclusive and never pulse in the same cycle as Start.

Decomposition:
- Shared package dma_ahb_pkg:
  - HTRANS_IDLE/NONSEQ/SEQ
  - HBURST_SINGLE/INCR
  - HSIZE_WORD
  - HRESP_OKAY/ERROR
  - the state enum
- One natural sub-module: dma_rd_skid, holding the one-word skid register with its capture/push/full logic.

Test Plan:
- Start SrcAddr=0x1000, Count=4, SrcIncr=1, zero-wait slave, FIFO empty → HADDR 0x1000/04/08/0C; HTRANS NONSEQ,SEQ,SEQ,SEQ; 4 pushes in order; Done 1 cycle after the last push.
- Count=20 with the FIFO read side stalled → exactly 16 pushes, full=1, HTRANS=IDLE with no lost word. Release reads → remaining 4 words arrive and Done pulses.
- SrcAddr=0x13F8, Count=4, SrcIncr=1 → beat at 0x1400 is NONSEQ. With SrcIncr=0, HADDR stays 0x13F8 for all beats, all NONSEQ, HBURST=000.
- Slave returns ERROR on the 3rd beat → 2 pushes only, HTRANS=IDLE in the first error cycle, Error pulses, Done never pulses, Busy=0.
- Deassert HGRANT after beat 2 for 5 cycles → no address issue during the gap, beat 3 re-issued as NONSEQ, all words correct.
- Deassert HRESETn mid-transfer → all outputs take reset values asynchronously. Start with Count=0 → Done the next cycle with no bus activity.
